// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and controller outputs.
// Pure wiring, no latency of its own.
// No backpressure; stall/flush outputs are the pipeline's backpressure.
interface hazard_ctrl_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic [REG_ADDR_W-1:0] rs1_e;
    logic [REG_ADDR_W-1:0] rs2_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic                  load_e;
    logic [REG_ADDR_W-1:0] rd_m;
    logic                  reg_write_m;
    logic                  mem_access_m;
    logic [REG_ADDR_W-1:0] rd_w;
    logic                  reg_write_w;
    logic                  pc_src_e;
    logic [1:0]            forward_ae;
    logic [1:0]            forward_be;
    logic                  stall_f;
    logic                  stall_d;
    logic                  stall_e;
    logic                  stall_m;
    logic                  flush_d;
    logic                  flush_e;
    logic                  flush_w;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    // Pipeline side: supplies register indices and control, consumes controls.
    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, rd_m, reg_write_m,
               mem_access_m, rd_w, reg_write_w, pc_src_e,
        input  forward_ae, forward_be, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, rd_m, reg_write_m,
               mem_access_m, rd_w, reg_write_w, pc_src_e,
        output forward_ae, forward_be, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall controller for a 5-stage RV32 pipeline: forwarding, load-use, flush, dmem wait states.
// Forward/stall/flush outputs are combinational; wait FSM and perf counters are registered.
// A memory wait freezes the whole front of the pipe and defers load-use and branch-flush handling.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int DMEM_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_unit_if.slave  hz
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Wide enough to hold DMEM_LAT-2, the first WAIT countdown value.
    localparam int              WC_W      = (DMEM_LAT > 2) ? $clog2(DMEM_LAT) : 1;
    localparam logic [WC_W-1:0] WAIT_INIT = (DMEM_LAT > 2) ? WC_W'(DMEM_LAT - 2) : '0;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(1);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            mem_stall;
    logic            load_use;
    logic [1:0]      fwd_a, fwd_b;
    logic            stall_fd, stall_em, flush_de, flush_dd, flush_mw;
    logic            stall_any;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Operand source select: Memory stage result beats Writeback, x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (hz.reg_write_m && (hz.rd_m != '0) && (hz.rd_m == rs))
            return 2'b10;
        else if (hz.reg_write_w && (hz.rd_w != '0) && (hz.rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Wait-state FSM register and countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Wait-state FSM next state; the stall is raised in the trigger cycle so a
    // memory op freezes for exactly DMEM_LAT-1 cycles, then RELEASE lets it leave M.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        if (DMEM_LAT > 1) begin
            case (state)
                IDLE: begin
                    if (hz.mem_access_m) begin
                        mem_stall    = 1'b1;
                        wait_cnt_nxt = WAIT_INIT;
                        state_nxt    = (DMEM_LAT == 2) ? RELEASE : WAIT;
                    end
                end
                WAIT: begin
                    mem_stall    = 1'b1;
                    wait_cnt_nxt = wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_LAST)
                        state_nxt = RELEASE;
                end
                RELEASE: begin
                    // The access completes now; mem_access_m still shows the departing op.
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Stall/flush/forward decisions; everything is held low while reset is asserted.
    always_comb begin
        fwd_a    = 2'b00;
        fwd_b    = 2'b00;
        stall_fd = 1'b0;
        stall_em = 1'b0;
        flush_dd = 1'b0;
        flush_de = 1'b0;
        flush_mw = 1'b0;
        load_use = hz.load_e && (hz.rd_e != '0) &&
                   ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
        if (!rst) begin
            fwd_a = fwd_sel(hz.rs1_e);
            fwd_b = fwd_sel(hz.rs2_e);
            if (mem_stall) begin
                // Freeze everything upstream of M; W gets bubbles until the access completes.
                stall_fd = 1'b1;
                stall_em = 1'b1;
                flush_mw = 1'b1;
            end else if (hz.pc_src_e) begin
                // Redirect wins over load-use: the dependent Decode op is wrong-path anyway.
                flush_dd = 1'b1;
                flush_de = 1'b1;
            end else if (load_use) begin
                stall_fd = 1'b1;
                flush_de = 1'b1;
            end
        end
    end

    assign stall_any = stall_fd || stall_em;

    // Performance counters: stalled cycles and taken-branch flush events, free-running wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_any)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_dd)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign hz.forward_ae = fwd_a;
    assign hz.forward_be = fwd_b;
    assign hz.stall_f    = stall_fd;
    assign hz.stall_d    = stall_fd;
    assign hz.stall_e    = stall_em;
    assign hz.stall_m    = stall_em;
    assign hz.flush_d    = flush_dd;
    assign hz.flush_e    = flush_de;
    assign hz.flush_w    = flush_mw;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: table of combinational vectors plus wait-state sequences.
// Two instances share all inputs: DMEM_LAT=4 and DMEM_LAT=3.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) if4 ();
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) if3 ();

    hazard_ctrl_unit #(.REG_ADDR_W(5), .DMEM_LAT(4), .CNT_W(32)) dut4 (
        .clk(clk), .rst(rst), .hz(if4.slave));
    hazard_ctrl_unit #(.REG_ADDR_W(5), .DMEM_LAT(3), .CNT_W(32)) dut3 (
        .clk(clk), .rst(rst), .hz(if3.slave));

    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, reg_write_m, mem_access_m, reg_write_w, pc_src_e;

    assign if4.rs1_d = rs1_d;           assign if3.rs1_d = rs1_d;
    assign if4.rs2_d = rs2_d;           assign if3.rs2_d = rs2_d;
    assign if4.rs1_e = rs1_e;           assign if3.rs1_e = rs1_e;
    assign if4.rs2_e = rs2_e;           assign if3.rs2_e = rs2_e;
    assign if4.rd_e = rd_e;             assign if3.rd_e = rd_e;
    assign if4.load_e = load_e;         assign if3.load_e = load_e;
    assign if4.rd_m = rd_m;             assign if3.rd_m = rd_m;
    assign if4.reg_write_m = reg_write_m;   assign if3.reg_write_m = reg_write_m;
    assign if4.mem_access_m = mem_access_m; assign if3.mem_access_m = mem_access_m;
    assign if4.rd_w = rd_w;             assign if3.rd_w = rd_w;
    assign if4.reg_write_w = reg_write_w;   assign if3.reg_write_w = reg_write_w;
    assign if4.pc_src_e = pc_src_e;     assign if3.pc_src_e = pc_src_e;

    typedef struct {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic       load_e;
        logic [4:0] rd_m;
        logic       reg_write_m;
        logic [4:0] rd_w;
        logic       reg_write_w;
        logic       pc_src_e;
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; load_e = 0;
        rd_m = 0; reg_write_m = 0; mem_access_m = 0; rd_w = 0; reg_write_w = 0;
        pc_src_e = 0;
    endtask

    // Advance to 1ns after the next rising edge (the input-change point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    // Checks the stall/flush group of the DMEM_LAT=4 instance.
    task automatic chk4(input string tag, input logic st, input logic fw,
                        input logic fd, input logic fe);
        chk({tag, ".stall_f"}, 32'(if4.stall_f), 32'(st));
        chk({tag, ".stall_d"}, 32'(if4.stall_d), 32'(st));
        chk({tag, ".stall_e"}, 32'(if4.stall_e), 32'(st));
        chk({tag, ".stall_m"}, 32'(if4.stall_m), 32'(st));
        chk({tag, ".flush_w"}, 32'(if4.flush_w), 32'(fw));
        chk({tag, ".flush_d"}, 32'(if4.flush_d), 32'(fd));
        chk({tag, ".flush_e"}, 32'(if4.flush_e), 32'(fe));
    endtask

    vec_t vecs[12];

    initial begin
        // rs1_d rs2_d rs1_e rs2_e rd_e load_e rd_m rwm rd_w rww pc | fa fb sf sd fd fe
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 5, 0, 0, 0, 5, 1, 5, 1, 0,  2, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 3, 3, 0, 0, 0, 0, 3, 1, 0,  1, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 9, 4, 0, 0, 4, 1, 9, 1, 0,  1, 2, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 6, 0, 0, 0, 6, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1};
        vecs[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[8]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1};
        vecs[10] = '{7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1};
        vecs[11] = '{0, 0, 8, 0, 0, 0, 8, 0, 8, 1, 0,  1, 0, 0, 0, 0, 0};

        // Reset state, sampled while rst is still high.
        clear_inputs();
        rd_m = 5; reg_write_m = 1; rs1_e = 5; mem_access_m = 1; pc_src_e = 1;
        #2;
        chk("rst.forward_ae", 32'(if4.forward_ae), 0);
        chk4("rst", 0, 0, 0, 0);
        chk("rst.stall_cnt", if4.stall_cnt, 0);
        chk("rst.flush_cnt", if4.flush_cnt, 0);
        do_reset();

        // Combinational vectors, one per cycle, no memory access.
        for (int i = 0; i < 12; i++) begin
            rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
            rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e;
            rd_e = vecs[i].rd_e;   load_e = vecs[i].load_e;
            rd_m = vecs[i].rd_m;   reg_write_m = vecs[i].reg_write_m;
            rd_w = vecs[i].rd_w;   reg_write_w = vecs[i].reg_write_w;
            pc_src_e = vecs[i].pc_src_e; mem_access_m = 0;
            #1;
            chk($sformatf("vec%0d.forward_ae", i), 32'(if4.forward_ae), 32'(vecs[i].fa));
            chk($sformatf("vec%0d.forward_be", i), 32'(if4.forward_be), 32'(vecs[i].fb));
            chk($sformatf("vec%0d.stall_f", i), 32'(if4.stall_f), 32'(vecs[i].sf));
            chk($sformatf("vec%0d.stall_d", i), 32'(if4.stall_d), 32'(vecs[i].sd));
            chk($sformatf("vec%0d.flush_d", i), 32'(if4.flush_d), 32'(vecs[i].fd));
            chk($sformatf("vec%0d.flush_e", i), 32'(if4.flush_e), 32'(vecs[i].fe));
            chk($sformatf("vec%0d.stall_m", i), 32'(if4.stall_m), 0);
            chk($sformatf("vec%0d.flush_w", i), 32'(if4.flush_w), 0);
            step();
        end
        clear_inputs();
        #1;
        chk("vec.stall_cnt", if4.stall_cnt, 1);
        chk("vec.flush_cnt", if4.flush_cnt, 2);

        // DMEM_LAT=4: access held in M across two back-to-back ops, forwarding stays live.
        do_reset();
        mem_access_m = 1; rd_m = 5; reg_write_m = 1; rs1_e = 5;
        for (int c = 0; c < 8; c++) begin
            logic st;
            st = (c != 3) && (c != 7);
            #1;
            chk4($sformatf("lat4.c%0d", c), st, st, 0, 0);
            chk($sformatf("lat4.c%0d.forward_ae", c), 32'(if4.forward_ae), 2);
            step();
        end
        clear_inputs();
        #1;
        chk("lat4.stall_cnt", if4.stall_cnt, 6);
        chk("lat4.idle_stall_f", 32'(if4.stall_f), 0);

        // DMEM_LAT=3: taken branch during wait is held until the release cycle.
        do_reset();
        mem_access_m = 1; pc_src_e = 1; load_e = 1; rd_e = 7; rs1_d = 7;
        for (int c = 0; c < 3; c++) begin
            logic st;
            st = (c < 2);
            #1;
            chk($sformatf("lat3.c%0d.stall_f", c), 32'(if3.stall_f), 32'(st));
            chk($sformatf("lat3.c%0d.stall_m", c), 32'(if3.stall_m), 32'(st));
            chk($sformatf("lat3.c%0d.flush_w", c), 32'(if3.flush_w), 32'(st));
            chk($sformatf("lat3.c%0d.flush_d", c), 32'(if3.flush_d), 32'(!st));
            chk($sformatf("lat3.c%0d.flush_e", c), 32'(if3.flush_e), 32'(!st));
            chk($sformatf("lat3.c%0d.stall_d", c), 32'(if3.stall_d), 32'(st));
            step();
        end
        clear_inputs();
        #1;
        chk("lat3.flush_cnt", if3.flush_cnt, 1);
        chk("lat3.stall_cnt", if3.stall_cnt, 2);

        // DMEM_LAT=4: asynchronous reset in the middle of WAIT.
        do_reset();
        mem_access_m = 1;
        step();
        #1;
        chk4("rstwait.pre", 1, 1, 0, 0);
        chk("rstwait.pre.stall_cnt", if4.stall_cnt, 1);
        rst = 1'b1;
        #1;
        chk4("rstwait.async", 0, 0, 0, 0);
        chk("rstwait.stall_cnt", if4.stall_cnt, 0);
        chk("rstwait.flush_cnt", if4.flush_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_access_m = 0;
        step();
        #1;
        chk4("rstwait.idle", 0, 0, 0, 0);
        chk("rstwait.idle.stall_cnt", if4.stall_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
